// File: rtl/axi4_lite_fanout_pkg.sv
// Shared types and constants for the AXI4-Lite 1-to-P fanout.
// Optional macro AXI4_LITE_FANOUT_DECERR_EN enables local DECERR termination.
package axi4_lite_fanout_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_FWD, W_RESP, W_ERR} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} rd_state_t;

  function automatic int clog2_region(input int m);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite bundle with pass-through IDs; master drives requests, slave drives responses.
interface axi4_if #(
  parameter int A = 16,
  parameter int N = 4,
  parameter int I = 1
);
  logic           awvalid, awready;
  logic [A-1:0]   awaddr;
  logic [2:0]     awprot;
  logic [I-1:0]   awid;
  logic           wvalid, wready;
  logic [N*8-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           bvalid, bready;
  logic [1:0]     bresp;
  logic [I-1:0]   bid;
  logic           arvalid, arready;
  logic [A-1:0]   araddr;
  logic [2:0]     arprot;
  logic [I-1:0]   arid;
  logic           rvalid, rready;
  logic [N*8-1:0] rdata;
  logic [1:0]     rresp;
  logic [I-1:0]   rid;

  modport master (
    output awvalid, awaddr, awprot, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, arid, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );
  modport slave (
    input  awvalid, awaddr, awprot, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, arid, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );
endinterface

// File: rtl/axi4_lite_fanout_decode.sv
// Region decoder: address -> master port index and in-range flag.
// Without AXI4_LITE_FANOUT_DECERR_EN every address hits and regions alias modulo P.
module axi4_lite_fanout_decode
  import axi4_lite_fanout_pkg::*;
#(
  parameter int A = 16,
  parameter int M = 'h0100,
  parameter int P = 4
) (
  input  logic [A-1:0]         addr,
  output logic [$clog2(P)-1:0] idx,
  output logic                 hit
);
  localparam int LGM = clog2_region(M);
  localparam int LGP = $clog2(P);

  logic [A-1:0] region;
  logic         unused_low;

  assign region     = addr >> LGM;
  assign unused_low = ^addr[LGM-1:0];

`ifdef AXI4_LITE_FANOUT_DECERR_EN
  assign idx = addr[LGM +: LGP];
  assign hit = region < A'(P);
`else
  assign idx = LGP'(region % A'(P));
  assign hit = 1'b1;
`endif

endmodule

// File: rtl/axi4_lite_fanout_n.sv
// One AXI4-Lite slave port fanned out to P master ports, one region of M bytes each.
// AXI4_LITE_FANOUT_DECERR_EN: out-of-range accesses get a local DECERR instead of aliasing.
module axi4_lite_fanout_n
  import axi4_lite_fanout_pkg::*;
#(
  parameter int A = 16,
  parameter int N = 4,
  parameter int M = 'h0100,
  parameter int I = 1,
  parameter int P = 4
) (
  input logic      aclk,
  input logic      aresetn,
  axi4_if.slave    axi4_s,
  axi4_if.master   axi4_m [P]
);
  localparam int LGP = $clog2(P);
  localparam int W   = N * 8;

  wr_state_t      wst;
  rd_state_t      rst;
  logic           aw_rdy, w_rdy, ar_rdy, aw_held, w_held, aw_pend, w_pend;
  logic [A-1:0]   awaddr_q, araddr_q;
  logic [2:0]     awprot_q, arprot_q;
  logic [I-1:0]   awid_q, arid_q;
  logic [W-1:0]   wdata_q;
  logic [N-1:0]   wstrb_q;
  logic [LGP-1:0] w_idx, r_idx;
  logic           w_hit, r_hit, aw_take, w_take, ar_take;

  logic [P-1:0]   m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]     m_bresp [P];
  logic [1:0]     m_rresp [P];
  logic [I-1:0]   m_bid [P];
  logic [I-1:0]   m_rid [P];
  logic [W-1:0]   m_rdata [P];

  assign aw_take = axi4_s.awvalid & aw_rdy;
  assign w_take  = axi4_s.wvalid & w_rdy;
  assign ar_take = axi4_s.arvalid & ar_rdy;

  // Decode the incoming address in the accept cycle, the latched one afterwards.
  axi4_lite_fanout_decode #(.A(A), .M(M), .P(P)) u_wdec (
    .addr(aw_take ? axi4_s.awaddr : awaddr_q), .idx(w_idx), .hit(w_hit));
  axi4_lite_fanout_decode #(.A(A), .M(M), .P(P)) u_rdec (
    .addr(ar_take ? axi4_s.araddr : araddr_q), .idx(r_idx), .hit(r_hit));

`ifndef AXI4_LITE_FANOUT_DECERR_EN
  logic unused_hit;
  assign unused_hit = w_hit ^ r_hit;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wst     <= W_IDLE;
      aw_rdy  <= 1'b0;
      w_rdy   <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      case (wst)
        W_IDLE, W_ADDR: begin
          if (aw_take) begin
            awaddr_q <= axi4_s.awaddr;
            awprot_q <= axi4_s.awprot;
            awid_q   <= axi4_s.awid;
            aw_held  <= 1'b1;
            aw_rdy   <= 1'b0;
          end else if (!aw_held) aw_rdy <= 1'b1;
          if (w_take) begin
            wdata_q <= axi4_s.wdata;
            wstrb_q <= axi4_s.wstrb;
            w_held  <= 1'b1;
            w_rdy   <= 1'b0;
          end else if (!w_held) w_rdy <= 1'b1;
          if ((aw_held | aw_take) && (w_held | w_take)) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
`ifdef AXI4_LITE_FANOUT_DECERR_EN
            wst <= w_hit ? W_FWD : W_ERR;
`else
            wst <= W_FWD;
`endif
          end else if (aw_held | aw_take | w_held | w_take) wst <= W_ADDR;
        end
        W_FWD: begin
          if (aw_pend && m_awready[w_idx]) aw_pend <= 1'b0;
          if (w_pend && m_wready[w_idx])   w_pend  <= 1'b0;
          if ((!aw_pend || m_awready[w_idx]) && (!w_pend || m_wready[w_idx])) wst <= W_RESP;
        end
        W_RESP: if (axi4_s.bvalid && axi4_s.bready) begin
          wst    <= W_IDLE;
          aw_rdy <= 1'b1;
          w_rdy  <= 1'b1;
        end
`ifdef AXI4_LITE_FANOUT_DECERR_EN
        W_ERR: if (axi4_s.bready) begin
          wst    <= W_IDLE;
          aw_rdy <= 1'b1;
          w_rdy  <= 1'b1;
        end
`endif
        default: wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rst    <= R_IDLE;
      ar_rdy <= 1'b0;
    end else begin
      case (rst)
        R_IDLE: if (ar_take) begin
          araddr_q <= axi4_s.araddr;
          arprot_q <= axi4_s.arprot;
          arid_q   <= axi4_s.arid;
          ar_rdy   <= 1'b0;
`ifdef AXI4_LITE_FANOUT_DECERR_EN
          rst <= r_hit ? R_FWD : R_ERR;
`else
          rst <= R_FWD;
`endif
        end else ar_rdy <= 1'b1;
        R_FWD:  if (m_arready[r_idx]) rst <= R_RESP;
        R_RESP: if (axi4_s.rvalid && axi4_s.rready) begin
          rst    <= R_IDLE;
          ar_rdy <= 1'b1;
        end
`ifdef AXI4_LITE_FANOUT_DECERR_EN
        R_ERR: if (axi4_s.rready) begin
          rst    <= R_IDLE;
          ar_rdy <= 1'b1;
        end
`endif
        default: rst <= R_IDLE;
      endcase
    end
  end

  assign axi4_s.awready = aw_rdy;
  assign axi4_s.wready  = w_rdy;
  assign axi4_s.arready = ar_rdy;

  always_comb begin
    axi4_s.bvalid = 1'b0;
    axi4_s.bresp  = RESP_OKAY;
    axi4_s.bid    = '0;
    if (wst == W_RESP) begin
      axi4_s.bvalid = m_bvalid[w_idx];
      axi4_s.bresp  = m_bresp[w_idx];
      axi4_s.bid    = m_bid[w_idx];
    end
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    if (wst == W_ERR) begin
      axi4_s.bvalid = 1'b1;
      axi4_s.bresp  = RESP_DECERR;
      axi4_s.bid    = awid_q;
    end
`endif
  end

  always_comb begin
    axi4_s.rvalid = 1'b0;
    axi4_s.rresp  = RESP_OKAY;
    axi4_s.rdata  = '0;
    axi4_s.rid    = '0;
    if (rst == R_RESP) begin
      axi4_s.rvalid = m_rvalid[r_idx];
      axi4_s.rresp  = m_rresp[r_idx];
      axi4_s.rdata  = m_rdata[r_idx];
      axi4_s.rid    = m_rid[r_idx];
    end
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    if (rst == R_ERR) begin
      axi4_s.rvalid = 1'b1;
      axi4_s.rresp  = RESP_DECERR;
      axi4_s.rid    = arid_q;
    end
`endif
  end

  for (genvar k = 0; k < P; k++) begin : g_port
    localparam logic [LGP-1:0] K = LGP'(k);
    logic w_sel, r_sel;
    assign w_sel = (w_idx == K);
    assign r_sel = (r_idx == K);

    assign axi4_m[k].awvalid = (wst == W_FWD) && aw_pend && w_sel;
    assign axi4_m[k].awaddr  = awaddr_q;
    assign axi4_m[k].awprot  = awprot_q;
    assign axi4_m[k].awid    = awid_q;
    assign axi4_m[k].wvalid  = (wst == W_FWD) && w_pend && w_sel;
    assign axi4_m[k].wdata   = wdata_q;
    assign axi4_m[k].wstrb   = wstrb_q;
    assign axi4_m[k].bready  = (wst == W_RESP) && w_sel && axi4_s.bready;
    assign axi4_m[k].arvalid = (rst == R_FWD) && r_sel;
    assign axi4_m[k].araddr  = araddr_q;
    assign axi4_m[k].arprot  = arprot_q;
    assign axi4_m[k].arid    = arid_q;
    assign axi4_m[k].rready  = (rst == R_RESP) && r_sel && axi4_s.rready;

    assign m_awready[k] = axi4_m[k].awready;
    assign m_wready[k]  = axi4_m[k].wready;
    assign m_bvalid[k]  = axi4_m[k].bvalid;
    assign m_bresp[k]   = axi4_m[k].bresp;
    assign m_bid[k]     = axi4_m[k].bid;
    assign m_arready[k] = axi4_m[k].arready;
    assign m_rvalid[k]  = axi4_m[k].rvalid;
    assign m_rresp[k]   = axi4_m[k].rresp;
    assign m_rdata[k]   = axi4_m[k].rdata;
    assign m_rid[k]     = axi4_m[k].rid;
  end

endmodule

// File: tb/tb_axi4_lite_fanout_n.sv
// Scoreboard bench for axi4_lite_fanout_n with randomised downstream register-file models.
// Expectations follow AXI4_LITE_FANOUT_DECERR_EN when it is defined for the build.
module tb_axi4_lite_fanout_n;
  localparam int A = 16, N = 4, M = 'h100, I = 1, P = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_if #(.A(A), .N(N), .I(I)) s_if ();
  axi4_if #(.A(A), .N(N), .I(I)) m_if [P] ();

  axi4_lite_fanout_n #(.A(A), .N(N), .M(M), .I(I), .P(P)) dut (
    .aclk(aclk), .aresetn(aresetn), .axi4_s(s_if), .axi4_m(m_if));

  int errors = 0, checks = 0, cyc = 0, s_aw_cyc = 0, b_done = 0, r_done = 0;
  bit hold_aw [P];
  always @(posedge aclk) cyc++;

  typedef struct { logic [1:0] resp; logic [I-1:0] id; } b_exp_t;
  typedef struct { logic [1:0] resp; logic [31:0] data; logic [I-1:0] id; } r_exp_t;
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [31:0] ref_mem [int];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference rules: region = addr / 256; a downstream slave flags offset 0xFC with SLVERR.
  function automatic bit in_range(input logic [15:0] a);
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    return (int'(a) / 256) < P;
`else
    return 1'b1;
`endif
  endfunction
  function automatic int port_of(input logic [15:0] a);
    return (int'(a) / 256) % P;
  endfunction
  function automatic logic [1:0] ok_resp(input logic [15:0] a);
    if (!in_range(a)) return 2'b11;
    return (a[7:0] == 8'hFC) ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  for (genvar k = 0; k < P; k++) begin : g_slv
    logic [31:0] mem [1024];
    int act_cnt = 0;
    int aw_rise_cyc = -1;
    logic [15:0] last_aw_addr = '0, last_ar_addr = '0;
    logic busy;
    assign busy = m_if[k].awvalid | m_if[k].wvalid | m_if[k].arvalid | m_if[k].bready | m_if[k].rready;

    initial begin
      logic prev_awv, rst_seen;
      bit aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w;
      logic [15:0] a_w, a_r;
      logic [31:0] d_w;
      logic [3:0] s_w;
      logic [I-1:0] id_w, id_r;
      for (int j = 0; j < 1024; j++) mem[j] = '0;
      prev_awv = 0; have_aw = 0; have_w = 0;
      m_if[k].awready = 0; m_if[k].wready = 0; m_if[k].bvalid = 0; m_if[k].bresp = 0;
      m_if[k].bid = 0; m_if[k].arready = 0; m_if[k].rvalid = 0; m_if[k].rdata = 0;
      m_if[k].rresp = 0; m_if[k].rid = 0;
      forever begin
        @(negedge aclk);
        rst_seen = !aresetn;
        aw_hs = m_if[k].awvalid & m_if[k].awready;
        w_hs  = m_if[k].wvalid & m_if[k].wready;
        b_hs  = m_if[k].bvalid & m_if[k].bready;
        ar_hs = m_if[k].arvalid & m_if[k].arready;
        r_hs  = m_if[k].rvalid & m_if[k].rready;
        if (busy) act_cnt++;
        if (m_if[k].awvalid && !prev_awv) aw_rise_cyc = cyc;
        prev_awv = m_if[k].awvalid;
        if (aw_hs) begin
          a_w = m_if[k].awaddr; id_w = m_if[k].awid; last_aw_addr = a_w;
          chk($sformatf("aw_port%0d_region", k), {in_range(a_w), 31'd0, port_of(a_w)}, {1'b1, 31'd0, k});
        end
        if (w_hs) begin d_w = m_if[k].wdata; s_w = m_if[k].wstrb; end
        if (ar_hs) begin
          a_r = m_if[k].araddr; id_r = m_if[k].arid; last_ar_addr = a_r;
          chk($sformatf("ar_port%0d_region", k), {in_range(a_r), 31'd0, port_of(a_r)}, {1'b1, 31'd0, k});
        end
        @(posedge aclk); #1;
        if (rst_seen) begin
          have_aw = 0; have_w = 0;
          m_if[k].awready = 0; m_if[k].wready = 0; m_if[k].bvalid = 0;
          m_if[k].arready = 0; m_if[k].rvalid = 0;
          continue;
        end
        if (aw_hs) have_aw = 1;
        if (w_hs)  have_w = 1;
        if (b_hs)  m_if[k].bvalid = 0;
        if (have_aw && have_w && !m_if[k].bvalid) begin
          for (int b = 0; b < 4; b++) if (s_w[b]) mem[a_w[11:2]][b*8 +: 8] = d_w[b*8 +: 8];
          m_if[k].bvalid = 1;
          m_if[k].bresp = (a_w[7:0] == 8'hFC) ? 2'b10 : 2'b00;
          m_if[k].bid = id_w;
          have_aw = 0; have_w = 0;
        end
        m_if[k].awready = !have_aw && !hold_aw[k] && ($urandom_range(0, 2) != 0);
        m_if[k].wready  = !have_w && ($urandom_range(0, 2) != 0);
        if (r_hs) m_if[k].rvalid = 0;
        if (ar_hs) begin
          m_if[k].rvalid = 1;
          m_if[k].rdata = mem[a_r[11:2]];
          m_if[k].rresp = (a_r[7:0] == 8'hFC) ? 2'b10 : 2'b00;
          m_if[k].rid = id_r;
        end
        m_if[k].arready = !m_if[k].rvalid && ($urandom_range(0, 2) != 0);
      end
    end
  end

  function automatic int sum_act();
    return g_slv[0].act_cnt + g_slv[1].act_cnt + g_slv[2].act_cnt + g_slv[3].act_cnt;
  endfunction
  function automatic logic any_busy();
    return g_slv[0].busy | g_slv[1].busy | g_slv[2].busy | g_slv[3].busy;
  endfunction

  // Response monitor: pops the expectation pushed when the request was issued.
  initial begin
    b_exp_t be;
    r_exp_t re;
    forever begin
      @(negedge aclk);
      if (aresetn && s_if.bvalid && s_if.bready) begin
        if (b_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = b_q.pop_front();
          chk("bresp", s_if.bresp, be.resp);
          chk("bid", s_if.bid, be.id);
        end
        b_done++;
      end
      if (aresetn && s_if.rvalid && s_if.rready) begin
        if (r_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = r_q.pop_front();
          chk("rresp", s_if.rresp, re.resp);
          chk("rdata", s_if.rdata, re.data);
          chk("rid", s_if.rid, re.id);
        end
        r_done++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      s_if.bready = ($urandom_range(0, 3) != 0);
      s_if.rready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_aw(input logic [15:0] a, input logic [I-1:0] id, input int dly);
    int n = 0;
    repeat (dly) @(posedge aclk);
    @(posedge aclk); #1;
    s_if.awvalid = 1; s_if.awaddr = a; s_if.awid = id; s_if.awprot = 3'($urandom);
    do begin @(negedge aclk); n++; end while (!s_if.awready && n < 500);
    chk("aw_accept", s_if.awready, 1);
    s_aw_cyc = cyc;
    @(posedge aclk); #1;
    s_if.awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) @(posedge aclk);
    @(posedge aclk); #1;
    s_if.wvalid = 1; s_if.wdata = d; s_if.wstrb = s;
    do begin @(negedge aclk); n++; end while (!s_if.wready && n < 500);
    chk("w_accept", s_if.wready, 1);
    @(posedge aclk); #1;
    s_if.wvalid = 0;
  endtask

  // w_lead > 0: W presented that many cycles before AW; < 0: AW first.
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [I-1:0] id, input int w_lead);
    int start, n;
    logic [31:0] v;
    if (in_range(a)) begin
      v = ref_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
      ref_mem[int'(a)] = v;
    end
    b_q.push_back('{resp: ok_resp(a), id: id});
    start = b_done;
    fork
      send_aw(a, id, (w_lead > 0) ? w_lead : 0);
      send_w(d, s, (w_lead < 0) ? -w_lead : 0);
    join
    n = 0;
    while (b_done == start && n < 1000) begin @(negedge aclk); n++; end
    chk("b_complete", b_done - start, 1);
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [I-1:0] id);
    int start, n;
    r_q.push_back('{resp: ok_resp(a), data: in_range(a) ? ref_read(a) : 32'h0, id: id});
    start = r_done;
    n = 0;
    @(posedge aclk); #1;
    s_if.arvalid = 1; s_if.araddr = a; s_if.arid = id; s_if.arprot = 3'($urandom);
    do begin @(negedge aclk); n++; end while (!s_if.arready && n < 500);
    chk("ar_accept", s_if.arready, 1);
    @(posedge aclk); #1;
    s_if.arvalid = 0;
    n = 0;
    while (r_done == start && n < 1000) begin @(negedge aclk); n++; end
    chk("r_complete", r_done - start, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, act0;
    logic [15:0] a;
    s_if.awvalid = 0; s_if.awaddr = 0; s_if.awprot = 0; s_if.awid = 0;
    s_if.wvalid = 0; s_if.wdata = 0; s_if.wstrb = 0; s_if.bready = 0;
    s_if.arvalid = 0; s_if.araddr = 0; s_if.arprot = 0; s_if.arid = 0; s_if.rready = 0;
    for (int k = 0; k < P; k++) hold_aw[k] = 0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", s_if.awready, 0);
    chk("rst_wready", s_if.wready, 0);
    chk("rst_arready", s_if.arready, 0);
    chk("rst_bvalid", s_if.bvalid, 0);
    chk("rst_rvalid", s_if.rvalid, 0);
    chk("rst_bresp", s_if.bresp, 0);
    chk("rst_rresp", s_if.rresp, 0);
    chk("rst_rdata", s_if.rdata, 0);
    chk("rst_master_busy", any_busy(), 0);
    @(posedge aclk); #1;
    aresetn = 1;

    repeat (20) @(negedge aclk);
    chk("idle_no_master_activity", sum_act(), 0);
    axi_read(16'h0004, 1'b0);

    for (int k = 0; k < P; k++)
      for (int i = 0; i < 8; i++)
        axi_write(16'(k * 'h100 + i * 4), $urandom,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF,
                  1'($urandom), $urandom_range(0, 4) - 2);
    for (int k = 0; k < P; k++)
      axi_write(16'(k * 'h100 + 'hFC), $urandom, 4'hF, 1'($urandom), 0);
    for (int k = 0; k < P; k++) begin
      for (int i = 0; i < 8; i++) axi_read(16'(k * 'h100 + i * 4), 1'($urandom));
      axi_read(16'(k * 'h100 + 'hFC), 1'($urandom));
    end

    axi_write(16'h0208, 32'hCAFE_0208, 4'hF, 1'b1, 3);
    chk("aw_rise_latency", g_slv[2].aw_rise_cyc - s_aw_cyc, 1);
    chk("aw_port2_addr", g_slv[2].last_aw_addr, 16'h0208);
    axi_read(16'h0208, 1'b0);

    fork
      axi_write(16'h0300, 32'h3300_AA55, 4'hF, 1'b0, 0);
      axi_read(16'h0104, 1'b1);
    join
    chk("concurrent_port3_aw", g_slv[3].last_aw_addr, 16'h0300);
    chk("concurrent_port1_ar", g_slv[1].last_ar_addr, 16'h0104);

    act0 = sum_act();
    axi_write(16'h0400, 32'h0400_BEEF, 4'hF, 1'b1, 0);
    axi_read(16'h0400, 1'b1);
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    chk("oob_no_master_activity", sum_act() - act0, 0);
`else
    chk("alias_port0_aw", g_slv[0].last_aw_addr, 16'h0400);
    chk("alias_port0_ar", g_slv[0].last_ar_addr, 16'h0400);
`endif
    axi_read(16'h0000, 1'b0);

    // Abort a write stuck in forwarding because port 1 withholds awready.
    hold_aw[1] = 1;
    fork
      send_aw(16'h0100, 1'b0, 0);
      send_w(32'hDEAD_0100, 4'hF, 0);
    join
    n = 0;
    while (!m_if[1].awvalid && n < 200) begin @(negedge aclk); n++; end
    chk("abort_fwd_reached", m_if[1].awvalid, 1);
    @(posedge aclk); #1;
    aresetn = 0;
    @(posedge aclk);
    @(negedge aclk);
    chk("abort_master_busy", any_busy(), 0);
    chk("abort_awready", s_if.awready, 0);
    chk("abort_bvalid", s_if.bvalid, 0);
    @(posedge aclk); #1;
    aresetn = 1;
    hold_aw[1] = 0;
    axi_write(16'h0100, 32'h0100_F00D, 4'hF, 1'b1, 1);
    axi_read(16'h0100, 1'b0);

    repeat (10) @(negedge aclk);
    chk("b_queue_drained", b_q.size(), 0);
    chk("r_queue_drained", r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_fanout_n.md
Name: axi4_lite_fanout_n

Overview:
- Parametrised successor to the two-port AXI4-Lite fanout: one AXI4-Lite slave port fanned out to P master ports.
- Each master port owns one M-byte address region: port k serves [k*M, (k+1)*M).
- Read and write paths have independent state machines, each with one transaction in flight.
- Out-of-range accesses are terminated locally with an error response.
- Sits between a CPU/bridge AXI4-Lite master and P register files or peripherals.

Parameters:
- A, 16, address width in bits.
- N, 4, data width in bytes; data bus is N*8 bits.
- M, 'h0100, region size in bytes; must be a power of two and at least N.
- I, 1, ID width; IDs are passed through unchanged.
- P, 4, number of master ports; 2 to 16.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- axi4_s  slave modport of axi4_if #(A,N)  upstream AXI4-Lite port.
- axi4_m[P]  master modport array of axi4_if #(A,N)  downstream ports; port k serves region k.

Behaviour:
- Reset (aresetn low at a clock edge): both FSMs go to IDLE. All axi4_m awvalid/wvalid/arvalid/bready/rready are 0. axi4_s awready/wready/arready/bvalid/rvalid are 0. bresp/rresp are 0 and rdata is 0. Reset aborts any transaction in flight; no response is issued for it.
- Decode: idx = addr[$clog2(M) +: $clog2(P)]; hit = (addr >> $clog2(M)) < P. Address is forwarded unmodified.
- Write FSM states: W_IDLE, W_ADDR, W_FWD, W_RESP, W_ERR.
  - W_IDLE: awready=wready=1. AW and W are latched independently, in either order or in the same cycle. After each is taken, its ready drops.
  - When both are held: go to W_FWD if hit, else W_ERR.
  - W_FWD: drive axi4_m[idx].awvalid and wvalid from the next cycle, so master awvalid rises 1 cycle after the later of AW/W acceptance. Each valid holds until its own ready; AW and W may complete in different cycles. Then go to W_RESP.
  - W_RESP: axi4_m[idx].bready = axi4_s.bready. bvalid, bresp and bid pass through combinationally. On the b handshake, return to W_IDLE with awready=wready=1 the next cycle.
  - W_ERR: axi4_s.bvalid=1, bresp=2'b11 (DECERR), bid=latched awid. No master port is touched. On bready, go to W_IDLE.
- Read FSM states: R_IDLE, R_FWD, R_RESP, R_ERR.
  - R_IDLE: arready=1. On AR handshake, latch the request; go to R_FWD if hit, else R_ERR.
  - R_FWD: axi4_m[idx].arvalid until arready, then R_RESP.
  - R_RESP: rvalid, rdata, rresp and rid pass through; rready passes back. On handshake, go to R_IDLE.
  - R_ERR: rvalid=1, rresp=2'b11, rdata=0. On rready, go to R_IDLE.
- Non-selected master ports see all valids/readies at 0.
- A read and a write may target the same or different ports concurrently; there is no arbitration between paths.
- Back-to-back throughput: at most one transaction per path per 3 cycles plus downstream latency.
- wstrb and awprot/arprot are latched and forwarded unchanged.
- Response pass-through is combinational; request channels are registered.

Optional Feature:
- Macro AXI4_LITE_FANOUT_DECERR_EN.
- Defined: out-of-range decode behaves as above (W_ERR/R_ERR, DECERR).
- Undefined: hit is forced to 1 and idx wraps modulo P (addresses alias). W_ERR and R_ERR are not built.

Decomposition:
- Package axi4_lite_fanout_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Enums wr_state_t and rd_state_t.
  - A function clog2_region(M).
- Sub-module axi4_lite_fanout_decode #(A,M,P), purely combinational: addr in; idx and hit out. It is shared by the read and write paths.

Test Plan:
- Reset then idle, P=4: no master valid asserts for 20 cycles; read of 'h04 returns port 0 data with rresp=0.
- Write 8 random words to each region at k*'h100 + i*4, then read all back: every word matches, and only axi4_m[k] shows activity for region k.
- W presented 3 cycles before AW at 'h0208: master port 2 receives AW and W; upstream sees bresp=0, and awvalid rises 1 cycle after AW acceptance.
- Concurrent write to 'h0300 and read from 'h0104 in the same cycle: both complete; port 3 gets the write and port 1 the read; no cross-talk.
- Access to 'h0400 with macro defined: bresp=2'b11, rresp=2'b11, rdata=0, no master activity. Without the macro, the access lands on port 0 at 'h0400.
- aresetn dropped while in W_FWD with port 1 holding awready=0: the next cycle has all valids at 0 and the FSMs in IDLE, and a subsequent write to 'h0100 completes normally.
